// File: rtl/point_relay_fifo.sv
// point_relay_fifo: single-clock DEPTH-entry relay between a point_slave_io
// receive port and a point_master_io transmit port. Valid/ready on both
// sides, optional drop-on-full mode, occupancy and drop statistics.
// No combinational path from the input port to the output port; the head
// word is read from registered storage indexed by a registered pointer.
module point_relay_fifo #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned DEPTH        = 4,
  parameter bit          DROP_ON_FULL = 1'b0,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic [CNT_W-1:0]           drop_count,
  input  logic                       clear_stats
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Storage and pointers. Pointers wrap naturally since DEPTH is a power of two.
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic drop;

  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);
  assign pop   = !empty && out_ready;

  // Input-side handshake: backpressure in mode 0, always-accept-or-drop in mode 1.
  always_comb begin
    in_ready = 1'b1;
    push     = 1'b0;
    drop     = 1'b0;
    if (DROP_ON_FULL) begin
      in_ready = 1'b1;
      // A same-cycle pop frees the slot, so the word is taken rather than dropped.
      push     = in_valid && (!full || pop);
      drop     = in_valid && full && !pop;
    end else begin
      // No pass-through when full: a simultaneous pop does not open in_ready.
      in_ready = !full;
      push     = in_valid && !full;
      drop     = 1'b0;
    end
  end

  // Next-state for pointers, occupancy and statistics.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    // Clear takes priority over a drop in the same cycle.
    if (clear_stats) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != CNT_MAX) drop_count_d = drop_count_q + CNT_ONE;
    end
  end

  // Control state with asynchronous reset; a reset discards all stored words.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Data storage needs no reset: out_data is masked to zero while empty.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // Output port driven purely from registered state.
  always_comb begin
    out_valid = !empty;
    out_data  = empty ? '0 : mem_q[rd_ptr_q];
  end

  assign level      = level_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_point_relay_fifo.sv
// Directed and scoreboard bench for point_relay_fifo: one backpressure
// instance and two drop-on-full instances (wide and 2-bit drop counters).
module tb_point_relay_fifo;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Instance 0: DEPTH 4, backpressure mode.
  logic       a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0, a_overflow;
  logic       a_clear = 0;
  logic [7:0] a_in_data = 0, a_out_data;
  logic [2:0] a_level;
  logic [15:0] a_drops;

  // Instance 1: DEPTH 4, drop-on-full, 16-bit counter.
  logic       b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0, b_overflow;
  logic       b_clear = 0;
  logic [7:0] b_in_data = 0, b_out_data;
  logic [2:0] b_level;
  logic [15:0] b_drops;

  // Instance 2: DEPTH 4, drop-on-full, 2-bit saturating counter.
  logic       c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0, c_overflow;
  logic       c_clear = 0;
  logic [7:0] c_in_data = 0, c_out_data;
  logic [2:0] c_level;
  logic [1:0] c_drops;

  point_relay_fifo #(.WIDTH(8), .DEPTH(4), .DROP_ON_FULL(1'b0), .CNT_W(16)) u_a (
    .clock(clock), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .level(a_level), .overflow(a_overflow),
    .drop_count(a_drops), .clear_stats(a_clear)
  );

  point_relay_fifo #(.WIDTH(8), .DEPTH(4), .DROP_ON_FULL(1'b1), .CNT_W(16)) u_b (
    .clock(clock), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .level(b_level), .overflow(b_overflow),
    .drop_count(b_drops), .clear_stats(b_clear)
  );

  point_relay_fifo #(.WIDTH(8), .DEPTH(4), .DROP_ON_FULL(1'b1), .CNT_W(2)) u_c (
    .clock(clock), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .level(c_level), .overflow(c_overflow),
    .drop_count(c_drops), .clear_stats(c_clear)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; inputs set after this are stable well before the next edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [7:0] sb[$];
  bit do_push, do_pop;

  initial begin
    // Reset state, sampled while reset is held.
    #2;
    check("rst_level", 32'(a_level), 32'd0);
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_out_data", 32'(a_out_data), 32'd0);
    check("rst_in_ready", 32'(a_in_ready), 32'd1);
    check("rst_overflow", 32'(b_overflow), 32'd0);
    check("rst_drops", 32'(b_drops), 32'd0);
    step();
    reset = 1'b0;

    // 1: single word, latency one cycle, then popped.
    a_in_valid = 1; a_in_data = 8'hA5; a_out_ready = 1;
    check("t1_pre_valid", 32'(a_out_valid), 32'd0);
    step();
    a_in_valid = 0;
    check("t1_out_valid", 32'(a_out_valid), 32'd1);
    check("t1_out_data", 32'(a_out_data), 32'hA5);
    check("t1_level1", 32'(a_level), 32'd1);
    step();
    check("t1_level0", 32'(a_level), 32'd0);
    check("t1_empty_valid", 32'(a_out_valid), 32'd0);
    check("t1_empty_data", 32'(a_out_data), 32'd0);

    // 2: fill with backpressure; 5 and 6 are refused.
    a_out_ready = 0;
    for (int i = 1; i <= 6; i++) begin
      a_in_valid = 1; a_in_data = 8'(i);
      check($sformatf("t2_in_ready_%0d", i), 32'(a_in_ready), (i <= 4) ? 32'd1 : 32'd0);
      step();
    end
    check("t2_level_full", 32'(a_level), 32'd4);
    check("t2_in_ready_full", 32'(a_in_ready), 32'd0);
    check("t2_head", 32'(a_out_data), 32'h01);

    // 3: full with push and pop offered: pop only.
    a_in_valid = 1; a_in_data = 8'h05; a_out_ready = 1;
    step();
    check("t3_level", 32'(a_level), 32'd3);
    check("t3_in_ready", 32'(a_in_ready), 32'd1);
    a_in_valid = 0;
    for (int k = 2; k <= 4; k++) begin
      check($sformatf("t2_drain_%0d", k), 32'(a_out_data), 32'(k));
      step();
    end
    check("t2_drained", 32'(a_level), 32'd0);
    a_out_ready = 0;

    // 4: drop-on-full, three drops, then full+push+pop accepts.
    for (int i = 0; i < 7; i++) begin
      b_in_valid = 1; b_in_data = (i < 4) ? 8'(8'h10 + i) : 8'(8'h20 + i);
      check($sformatf("t4_in_ready_%0d", i), 32'(b_in_ready), 32'd1);
      step();
    end
    check("t4_overflow", 32'(b_overflow), 32'd1);
    check("t4_drops", 32'(b_drops), 32'd3);
    check("t4_level", 32'(b_level), 32'd4);
    check("t4_head", 32'(b_out_data), 32'h10);
    b_in_data = 8'h30; b_out_ready = 1;
    step();
    b_in_valid = 0;
    check("t4_pp_level", 32'(b_level), 32'd4);
    check("t4_pp_drops", 32'(b_drops), 32'd3);
    check("t4_d0", 32'(b_out_data), 32'h11); step();
    check("t4_d1", 32'(b_out_data), 32'h12); step();
    check("t4_d2", 32'(b_out_data), 32'h13); step();
    check("t4_d3", 32'(b_out_data), 32'h30); step();
    check("t4_empty", 32'(b_level), 32'd0);

    // 5: 2-bit counter saturates, clear wins over a simultaneous drop.
    for (int i = 0; i < 9; i++) begin
      c_in_valid = 1; c_in_data = 8'(8'h40 + i);
      step();
    end
    check("t5_sat", 32'(c_drops), 32'd3);
    check("t5_overflow", 32'(c_overflow), 32'd1);
    c_clear = 1;
    step();
    check("t5_clear_drops", 32'(c_drops), 32'd0);
    check("t5_clear_ovf", 32'(c_overflow), 32'd0);
    check("t5_clear_level", 32'(c_level), 32'd4);
    c_clear = 0;
    step();
    check("t5_redrop", 32'(c_drops), 32'd1);
    c_in_valid = 0;
    check("t5_head", 32'(c_out_data), 32'h40);

    // 6: reset mid-burst clears immediately, without waiting for an edge.
    a_out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1; a_in_data = 8'(8'h70 + i);
      step();
    end
    a_in_valid = 0;
    check("t6_pre_level", 32'(a_level), 32'd3);
    reset = 1'b1;
    #1;
    check("t6_rst_valid", 32'(a_out_valid), 32'd0);
    check("t6_rst_level", 32'(a_level), 32'd0);
    step();
    reset = 1'b0;
    step();

    // 6: randomised traffic against a queue model.
    for (int n = 0; n < 10000; n++) begin
      a_in_valid  = 1'($urandom_range(0, 1));
      a_out_ready = 1'($urandom_range(0, 1));
      a_in_data   = 8'($urandom);
      do_push = a_in_valid && (sb.size() != 4);
      do_pop  = a_out_ready && (sb.size() != 0);
      step();
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back(a_in_data);
      check("rnd_level", 32'(a_level), 32'(sb.size()));
      check("rnd_valid", 32'(a_out_valid), (sb.size() != 0) ? 32'd1 : 32'd0);
      check("rnd_data", 32'(a_out_data), (sb.size() != 0) ? 32'(sb[0]) : 32'd0);
      check("rnd_in_ready", 32'(a_in_ready), (sb.size() != 4) ? 32'd1 : 32'd0);
    end
    check("rnd_no_drops", 32'(a_drops), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
